reg_write_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of one 64-bit enabled register among several requesters. Each cycle it picks at most one pending requester. It drives the register's enable and data inputs from registered outputs and returns a one-cycle acknowledge to the winner. It sits directly in front of the 64-bit register, with `wr_en` wired to the register's `en` and `wr_data` wired to its `in`.

---
 rtl/reg_write_arbiter.sv | 60 ++++++
 tb/tb_reg_write_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register write port among N requesters.
// Latency: 1 edge from req sampling to wr_en/wr_data/ack; the register captures on the following edge.
// No backpressure: a requester holds req/data until its one-cycle ack; an acked requester is masked for that cycle.
module reg_write_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 64,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data,
    output logic                 wr_en,
    output logic [WIDTH-1:0]     wr_data,
    output logic [SELW-1:0]      wr_sel,
    output logic [N-1:0]         ack
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] win;
    logic [SELW-1:0] ptr_nxt;
    logic            found;
    logic [N-1:0]    elig;

    // Masking by ack keeps a requester that still holds req from being written twice.
    assign elig = req & ~ack;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && elig[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = SELW'((int'(ptr) + k) % N);
            end
        end
    end

    assign ptr_nxt = (win == SELW'(N - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
            wr_sel  <= '0;
            ack     <= '0;
        end else if (found) begin
            ptr     <= ptr_nxt;
            wr_en   <= 1'b1;
            wr_data <= data[int'(win)*WIDTH +: WIDTH];
            wr_sel  <= win;
            ack     <= {{(N-1){1'b0}}, 1'b1} << win;
        end else begin
            wr_en   <= 1'b0;
            ack     <= '0;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a queue-free behavioural model of the arbitration rules.
module tb_reg_write_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [W-1:0]  dv [N];
    logic [N*W-1:0] data;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic [1:0]    wr_sel;
    logic [N-1:0]  ack;

    int checks = 0;
    int errors = 0;

    assign data = {dv[3], dv[2], dv[1], dv[0]};

    reg_write_arbiter #(.N(N), .WIDTH(W), .SELW(2)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data),
        .wr_en(wr_en), .wr_data(wr_data), .wr_sel(wr_sel), .ack(ack)
    );

    always #5 clk = ~clk;

    // Downstream 64-bit enabled register fed by the arbiter.
    logic [W-1:0] reg_q = '0;
    always @(posedge clk) if (wr_en) reg_q <= wr_data;

    // Behavioural model: requesters eligible unless acked last cycle; first eligible at or after ptr wins.
    int           m_ptr = 0;
    logic         m_en = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_sel = 0;
    logic [N-1:0] m_ack = '0;

    always @(posedge clk or posedge reset) begin
        int w;
        if (reset) begin
            m_ptr = 0; m_en = 1'b0; m_data = '0; m_sel = 0; m_ack = '0;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && req[j] && !m_ack[j]) w = j;
            end
            if (w >= 0) begin
                m_en = 1'b1; m_data = dv[w]; m_sel = w;
                m_ack = '0; m_ack[w] = 1'b1;
                m_ptr = (w + 1) % N;
            end else begin
                m_en = 1'b0; m_ack = '0;
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_wr_en",   W'(wr_en),   W'(m_en));
            chk("model_wr_data", wr_data,     m_data);
            chk("model_wr_sel",  W'(wr_sel),  W'(m_sel));
            chk("model_ack",     W'(ack),     W'(m_ack));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [N-1:0] pats [7];

    initial begin
        for (int i = 0; i < N; i++) dv[i] = '0;
        cyc(); cyc();
        chk("reset_wr_en", W'(wr_en), 0);
        chk("reset_ack", W'(ack), 0);
        chk("reset_wr_data", wr_data, 0);
        reset = 1'b0;

        // Rotation with all requesters pending, ptr starts at 0.
        for (int i = 0; i < N; i++) dv[i] = W'(i + 1);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rot_wr_en", W'(wr_en), 1);
            chk("rot_wr_sel", W'(wr_sel), W'(i % 4));
            chk("rot_wr_data", wr_data, W'(i % 4 + 1));
            if (i == 7) req = '0;
        end
        cyc();
        chk("rot_end_idle", W'(wr_en), 0);

        // Lone requester 1: written every other cycle.
        dv[1] = 64'h5;
        req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("mask_wr_en", W'(wr_en), W'((i % 2) == 0));
            chk("mask_ack1", W'(ack[1]), W'((i % 2) == 0));
        end
        req = '0;

        // Idle hold after a grant to requester 1 carrying 5.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_wr_en", W'(wr_en), 0);
            chk("idle_ack", W'(ack), 0);
            chk("idle_wr_data", wr_data, 64'h5);
            chk("idle_wr_sel", W'(wr_sel), 1);
        end

        // Single request from requester 2 (ptr is 2 here).
        dv[2] = 64'hDEAD_BEEF_0000_0001;
        req = 4'b0100;
        cyc();
        chk("single_wr_en", W'(wr_en), 1);
        chk("single_wr_data", wr_data, 64'hDEAD_BEEF_0000_0001);
        chk("single_wr_sel", W'(wr_sel), 2);
        chk("single_ack", W'(ack), 4'b0100);
        req = '0;
        cyc();
        chk("single_reg_q", reg_q, 64'hDEAD_BEEF_0000_0001);

        // Pointer wrap: ptr is 3 after the grant to 2.
        dv[0] = 64'hA0; dv[3] = 64'hA3;
        req = 4'b1001;
        cyc();
        chk("wrap_first_sel", W'(wr_sel), 3);
        chk("wrap_first_ack", W'(ack), 4'b1000);
        req = 4'b0001;
        cyc();
        chk("wrap_second_sel", W'(wr_sel), 0);
        chk("wrap_second_data", wr_data, 64'hA0);
        chk("wrap_model_ptr", W'(m_ptr), 1);
        req = 4'b0011;
        dv[1] = 64'hB1;
        cyc();
        chk("wrap_ptr_is_1", W'(wr_sel), 1);
        req = '0;
        cyc();

        // Asynchronous reset while a write is being issued.
        req = 4'b1111;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_wr_en", W'(wr_en), 0);
        chk("arst_ack", W'(ack), 0);
        chk("arst_wr_data", wr_data, 0);
        chk("arst_wr_sel", W'(wr_sel), 0);
        cyc();
        chk("arst_hold_ack", W'(ack), 0);
        req = '0;
        reset = 1'b0;
        cyc();
        chk("post_rst_wr_en", W'(wr_en), 0);
        cyc();
        chk("post_rst_wr_en2", W'(wr_en), 0);

        // Mixed patterns, checked against the model each cycle.
        pats = '{4'b0101, 4'b0110, 4'b1010, 4'b0011, 4'b1100, 4'b0000, 4'b1111};
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < N; j++) dv[j] = W'(64'h100 * (i + 1) + j);
            req = pats[i];
            cyc(); cyc();
        end
        req = '0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
